// File: rtl/kf8259_pkg.sv
// Shared types and helpers for the 8259 in-service / priority logic.
package kf8259_pkg;

    localparam int IR_COUNT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    // Rotate an IR vector right so that bit 'amount' lands at index 0.
    function automatic logic [7:0] rotate_right(input logic [7:0] vec, input logic [2:0] amount);
        logic [15:0] doubled;
        doubled = {vec, vec} >> amount;
        return doubled[7:0];
    endfunction

    // Inverse of rotate_right.
    function automatic logic [7:0] rotate_left(input logic [7:0] vec, input logic [2:0] amount);
        logic [15:0] doubled;
        doubled = {vec, vec} << amount;
        return doubled[15:8];
    endfunction

    function automatic logic [2:0] one_hot_to_level(input logic [7:0] vec);
        logic [2:0] level;
        level = 3'd0;
        for (int i = 0; i < IR_COUNT; i++) begin
            if (vec[i]) level = 3'(i);
        end
        return level;
    endfunction

    function automatic logic [7:0] level_to_one_hot(input logic [2:0] level);
        return 8'b0000_0001 << level;
    endfunction

endpackage

// File: rtl/kf8259_priority_resolver.sv
// Picks the highest-priority set bit of a vector under rotating priority.
// The highest level is lowest_priority+1 (mod 8), descending cyclically.
module kf8259_priority_resolver
    import kf8259_pkg::*;
(
    input  logic [7:0] request,
    input  logic [2:0] lowest_priority,
    output logic [7:0] one_hot,
    output logic [2:0] level,
    output logic       valid
);

    logic [2:0] amount;
    logic [7:0] rotated;
    logic [7:0] rotated_pick;

    // Rotate so the highest-priority level sits at bit 0, isolate the
    // lowest set bit, then rotate back to absolute IR numbering.
    assign amount       = lowest_priority + 3'd1;
    assign rotated      = rotate_right(request, amount);
    assign rotated_pick = rotated & (~rotated + 8'd1);
    assign one_hot      = rotate_left(rotated_pick, amount);
    assign level        = one_hot_to_level(one_hot);
    assign valid        = |request;

endmodule

// File: rtl/kf8259_in_service_control.sv
// 8259 in-service control: priority resolution, INT generation, the
// two-pulse INTA sequence, ISR maintenance, EOI and priority rotation.
module kf8259_in_service_control
    import kf8259_pkg::*;
#(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] interrupt_mask,
    input  logic       auto_eoi_config,
    input  logic       rotate_in_auto_eoi,
    input  logic       end_of_interrupt,
    input  logic       eoi_specific,
    input  logic       eoi_rotate,
    input  logic [2:0] eoi_level,
    input  logic       set_priority,
    input  logic [2:0] priority_level,
    input  logic       interrupt_acknowledge_start,
    input  logic       interrupt_acknowledge_end,
    output logic       interrupt_to_cpu,
    output logic [7:0] in_service_register,
    output logic [7:0] clear_interrupt_request,
    output logic [2:0] interrupt_vector_level,
    output logic       spurious_interrupt
);

    state_t     state;
    state_t     state_next;
    logic [2:0] lowest_priority;
    logic [2:0] lowest_priority_next;
    logic [7:0] isr_next;
    logic [7:0] candidates;
    logic [7:0] req_one_hot;
    logic [7:0] isr_one_hot;
    logic [2:0] req_level;
    logic [2:0] isr_level;
    logic       req_valid;
    logic       isr_valid;
    logic [2:0] req_rank;
    logic [2:0] isr_rank;
    logic       first_ack;
    logic       second_ack;
    logic       int_next;

    assign candidates = interrupt_request_register & ~interrupt_mask;

    kf8259_priority_resolver u_request_resolver (
        .request         (candidates),
        .lowest_priority (lowest_priority),
        .one_hot         (req_one_hot),
        .level           (req_level),
        .valid           (req_valid)
    );

    kf8259_priority_resolver u_in_service_resolver (
        .request         (in_service_register),
        .lowest_priority (lowest_priority),
        .one_hot         (isr_one_hot),
        .level           (isr_level),
        .valid           (isr_valid)
    );

    // Rank 0 is the highest priority; 3-bit wraparound gives the cyclic order.
    assign req_rank = req_level - lowest_priority - 3'd1;
    assign isr_rank = isr_level - lowest_priority - 3'd1;

    assign first_ack  = (state == IDLE) && interrupt_acknowledge_start;
    assign second_ack = (state == ACK) && interrupt_acknowledge_end;

    // Acknowledge FSM next state; pulses in the wrong state are ignored.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (interrupt_acknowledge_start) state_next = ACK;
            ACK:     if (interrupt_acknowledge_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ISR and rotation update. EOI sees last cycle's ISR; a first-INTA set
    // is applied last so it wins over a clear of the same bit, and
    // set_priority is applied last so it wins over any rotation.
    always_comb begin
        isr_next             = in_service_register;
        lowest_priority_next = lowest_priority;
        if (end_of_interrupt) begin
            if (eoi_specific) begin
                isr_next = isr_next & ~level_to_one_hot(eoi_level);
                if (eoi_rotate) lowest_priority_next = eoi_level;
            end else if (isr_valid) begin
                isr_next = isr_next & ~isr_one_hot;
                if (eoi_rotate) lowest_priority_next = isr_level;
            end
        end
        if (second_ack && auto_eoi_config && !spurious_interrupt) begin
            isr_next = isr_next & ~level_to_one_hot(interrupt_vector_level);
            if (rotate_in_auto_eoi) lowest_priority_next = interrupt_vector_level;
        end
        if (first_ack && req_valid) begin
            isr_next = isr_next | req_one_hot;
        end
        if (set_priority) begin
            lowest_priority_next = priority_level;
        end
    end

    // INT request: held low for the whole acknowledge, otherwise raised when a
    // candidate exists and nothing of equal or higher priority is in service.
    assign int_next = (state_next == IDLE) && req_valid &&
                      (!isr_valid || (req_rank < isr_rank));

    // State, ISR, priority and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= IDLE;
            in_service_register     <= 8'h00;
            lowest_priority         <= 3'd7;
            interrupt_to_cpu        <= 1'b0;
            clear_interrupt_request <= 8'h00;
            interrupt_vector_level  <= 3'd0;
            spurious_interrupt      <= 1'b0;
        end else begin
            state                   <= state_next;
            in_service_register     <= isr_next;
            lowest_priority         <= lowest_priority_next;
            interrupt_to_cpu        <= int_next;
            clear_interrupt_request <= 8'h00;
            if (first_ack) begin
                if (req_valid) begin
                    interrupt_vector_level  <= req_level;
                    clear_interrupt_request <= req_one_hot;
                    spurious_interrupt      <= 1'b0;
                end else begin
                    interrupt_vector_level  <= SPURIOUS_LEVEL;
                    spurious_interrupt      <= 1'b1;
                end
            end
        end
    end

endmodule
